// File: rtl/seven_seg_pkg.sv
// Shared glyph table, glyph codes and sizing helpers for the seven-segment scan display.
package seven_seg_pkg;

    // Active-high segment patterns, bit0 = segment a ... bit6 = segment g
    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_B     = 7'h7C;
    localparam logic [6:0] GLYPH_C     = 7'h39;
    localparam logic [6:0] GLYPH_D     = 7'h5E;
    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_F     = 7'h71;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    // Glyph codes: 0x00-0x0F are plain nibbles, the two specials sit above them
    localparam logic [4:0] CODE_DASH  = 5'h10;
    localparam logic [4:0] CODE_BLANK = 5'h11;

    // Converter control states
    typedef enum logic {
        CONV_IDLE,
        CONV_RUN
    } conv_state_t;

    // Map a glyph code to its active-high segment pattern
    function automatic logic [6:0] glyphLookup(input logic [4:0] code);
        logic [6:0] pattern;
        case (code)
            5'h00:   pattern = GLYPH_0;
            5'h01:   pattern = GLYPH_1;
            5'h02:   pattern = GLYPH_2;
            5'h03:   pattern = GLYPH_3;
            5'h04:   pattern = GLYPH_4;
            5'h05:   pattern = GLYPH_5;
            5'h06:   pattern = GLYPH_6;
            5'h07:   pattern = GLYPH_7;
            5'h08:   pattern = GLYPH_8;
            5'h09:   pattern = GLYPH_9;
            5'h0A:   pattern = GLYPH_A;
            5'h0B:   pattern = GLYPH_B;
            5'h0C:   pattern = GLYPH_C;
            5'h0D:   pattern = GLYPH_D;
            5'h0E:   pattern = GLYPH_E;
            5'h0F:   pattern = GLYPH_F;
            5'h10:   pattern = GLYPH_DASH;
            default: pattern = GLYPH_BLANK;
        endcase
        return pattern;
    endfunction

    // Ceil-log2 that never returns less than 1, so single-value counters still get a bit
    function automatic int ceilLog2(input int n);
        int bits;
        bits = 1;
        while ((64'd1 << bits) < 64'(n)) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/seven_seg_bin2bcd.sv
// Iterative double-dabble converter: one shift-add-3 step per cycle, VALUE_W steps per value.
// One spare BCD digit (plus a sticky carry-out) detects values too large for NUM_DIGITS.
// The final result and done flag are presented combinationally during the last step so the
// consumer can latch them on the same edge that busy falls.
module seven_seg_bin2bcd
    import seven_seg_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [VALUE_W-1:0]      i_value,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic                    o_overflow
);

    localparam int BCD_W = 4 * (NUM_DIGITS + 1);
    localparam int CNT_W = ceilLog2(VALUE_W + 1);

    conv_state_t        r_state;
    logic [VALUE_W-1:0] r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_lost;
    logic [CNT_W-1:0]   r_count;

    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_shifted;
    logic               w_lost_next;
    logic               w_last;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS + 1; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_shifted   = {w_adj[BCD_W-2:0], r_bin[VALUE_W-1]};
        w_lost_next = r_lost | w_adj[BCD_W-1];
        w_last      = (r_state == CONV_RUN) && (r_count == CNT_W'(VALUE_W - 1));
    end

    assign o_busy     = (r_state == CONV_RUN);
    assign o_done     = w_last;
    assign o_bcd      = w_shifted[4*NUM_DIGITS-1:0];
    assign o_overflow = w_lost_next | (w_shifted[BCD_W-1 -: 4] != 4'd0);

    // Converter FSM: capture on start, then step once per cycle until the last bit is in
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= CONV_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_lost  <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                CONV_IDLE: begin
                    if (i_start) begin
                        r_bin   <= i_value;
                        r_bcd   <= '0;
                        r_lost  <= 1'b0;
                        r_count <= '0;
                        r_state <= CONV_RUN;
                    end
                end
                CONV_RUN: begin
                    r_bcd   <= w_shifted;
                    r_bin   <= r_bin << 1;
                    r_lost  <= w_lost_next;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_state <= CONV_IDLE;
                    end
                end
                default: r_state <= CONV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_scan_display.sv
// Time-multiplexed seven-segment driver: holds the display register, scans one digit at a
// time, blanks leading zeros, shows dashes on decimal overflow and blinks the whole display.
// Outputs are registered from next-state values so anode and seg always switch together
// and reflect the display register on the same edge it changes.
module seven_seg_scan_display
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int CLK_HZ     = 50000000,
    parameter int SCAN_HZ    = 1000,
    parameter int BLINK_HZ   = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [VALUE_W-1:0]    i_value,
    input  logic                  i_value_valid,
    input  logic                  i_hex_mode,
    input  logic                  i_blank_lz,
    input  logic                  i_blink_en,
    output logic                  o_busy,
    output logic [NUM_DIGITS-1:0] o_anode,
    output logic [6:0]            o_seg
);

    localparam int   DWELL      = CLK_HZ / SCAN_HZ;
    localparam int   BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int   DW_W       = ceilLog2(DWELL);
    localparam int   BL_W       = ceilLog2(BLINK_HALF);
    localparam int   IDX_W      = ceilLog2(NUM_DIGITS);
    localparam int   DISP_W     = 4 * NUM_DIGITS;
    localparam int   PAD_W      = (VALUE_W > DISP_W) ? VALUE_W : DISP_W;
    localparam logic POL_LOW    = (ACTIVE_LOW != 0);

    logic [DW_W-1:0]       r_dwell;
    logic [IDX_W-1:0]      r_index;
    logic [BL_W-1:0]       r_blink;
    logic                  r_phase;
    logic [DISP_W-1:0]     r_digits;
    logic                  r_ovf;
    logic [NUM_DIGITS-1:0] r_anode;
    logic [6:0]            r_seg;

    logic                  w_conv_busy;
    logic                  w_conv_done;
    logic [DISP_W-1:0]     w_conv_bcd;
    logic                  w_conv_ovf;
    logic                  w_load;
    logic                  w_start;
    logic [PAD_W-1:0]      w_pad;
    logic [DISP_W-1:0]     w_hex;

    logic [DW_W-1:0]       w_dwell_next;
    logic [IDX_W-1:0]      w_index_next;
    logic [BL_W-1:0]       w_blink_next;
    logic                  w_phase_next;
    logic [DISP_W-1:0]     w_digits_next;
    logic                  w_ovf_next;

    logic [NUM_DIGITS-1:0] w_lz_blank;
    logic                  w_all_zero;
    logic [3:0]            w_cur_nibble;
    logic                  w_cur_blank;
    logic [4:0]            w_code;
    logic                  w_display_on;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [NUM_DIGITS-1:0] w_anode_drive;
    logic [6:0]            w_seg_drive;

    // A load is taken only while the converter is idle; hex loads bypass it entirely
    assign w_load  = i_value_valid && !w_conv_busy;
    assign w_start = w_load && !i_hex_mode;
    assign w_pad   = PAD_W'(i_value);
    assign w_hex   = w_pad[DISP_W-1:0];
    assign o_busy  = w_conv_busy;

    seven_seg_bin2bcd #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (w_start),
        .i_value    (i_value),
        .o_busy     (w_conv_busy),
        .o_done     (w_conv_done),
        .o_bcd      (w_conv_bcd),
        .o_overflow (w_conv_ovf)
    );

    // Dwell and blink counters: the digit index steps on dwell wrap, the phase flips on blink wrap
    always_comb begin
        w_dwell_next = r_dwell + 1'b1;
        w_index_next = r_index;
        if (r_dwell == DW_W'(DWELL - 1)) begin
            w_dwell_next = '0;
            if (r_index == IDX_W'(NUM_DIGITS - 1)) begin
                w_index_next = '0;
            end else begin
                w_index_next = r_index + 1'b1;
            end
        end
        w_blink_next = r_blink + 1'b1;
        w_phase_next = r_phase;
        if (r_blink == BL_W'(BLINK_HALF - 1)) begin
            w_blink_next = '0;
            w_phase_next = ~r_phase;
        end
    end

    // Display register next value: a finished conversion lands atomically, hex loads land at once
    always_comb begin
        w_digits_next = r_digits;
        w_ovf_next    = r_ovf;
        if (w_conv_done) begin
            w_digits_next = w_conv_bcd;
            w_ovf_next    = w_conv_ovf;
        end else if (w_load && i_hex_mode) begin
            w_digits_next = w_hex;
            w_ovf_next    = 1'b0;
        end
    end

    // Leading-zero mask: walk down from the top digit while everything seen so far is zero
    always_comb begin
        w_all_zero = 1'b1;
        w_lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_all_zero    = w_all_zero && (w_digits_next[4*i +: 4] == 4'd0);
            w_lz_blank[i] = i_blank_lz && w_all_zero && (i != 0);
        end
    end

    // Pick the selected digit, resolve its glyph and build the one-hot anode pattern
    always_comb begin
        w_cur_nibble = 4'd0;
        w_cur_blank  = 1'b0;
        w_onehot     = '0;
        w_display_on = !i_blink_en || w_phase_next;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_index_next == IDX_W'(i)) begin
                w_cur_nibble = w_digits_next[4*i +: 4];
                w_cur_blank  = w_lz_blank[i];
                w_onehot[i]  = w_display_on;
            end
        end
        if (w_ovf_next) begin
            w_code = CODE_DASH;
        end else if (w_cur_blank) begin
            w_code = CODE_BLANK;
        end else begin
            w_code = {1'b0, w_cur_nibble};
        end
        w_seg_drive   = POL_LOW ? ~glyphLookup(w_code) : glyphLookup(w_code);
        w_anode_drive = POL_LOW ? ~w_onehot : w_onehot;
    end

    // Scan and blink state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dwell <= '0;
            r_index <= '0;
            r_blink <= '0;
            r_phase <= 1'b1;
        end else begin
            r_dwell <= w_dwell_next;
            r_index <= w_index_next;
            r_blink <= w_blink_next;
            r_phase <= w_phase_next;
        end
    end

    // Display register; a reset in the middle of a conversion leaves it cleared
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_digits <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_digits <= w_digits_next;
            r_ovf    <= w_ovf_next;
        end
    end

    // Registered pin drivers, parked at the inactive level during reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_anode <= POL_LOW ? '1 : '0;
            r_seg   <= POL_LOW ? 7'h7F : 7'h00;
        end else begin
            r_anode <= w_anode_drive;
            r_seg   <= w_seg_drive;
        end
    end

    assign o_anode = r_anode;
    assign o_seg   = r_seg;

endmodule

// File: tb/tb_seven_seg_scan_display.sv
// Directed bench for the seven-segment scan display with hand-computed expected patterns.
module tb_seven_seg_scan_display;

    logic        clk;
    logic        rstN;
    logic [13:0] value;
    logic        valueValid;
    logic        hexMode;
    logic        blankLz;
    logic        blinkEn;
    logic        busy;
    logic [3:0]  anode;
    logic [6:0]  seg;

    int testsRun;
    int testsFailed;

    // Active-low patterns used throughout
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    seven_seg_scan_display #(
        .NUM_DIGITS (4),
        .VALUE_W    (14),
        .CLK_HZ     (1000),
        .SCAN_HZ    (100),
        .BLINK_HZ   (5),
        .ACTIVE_LOW (1)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_value       (value),
        .i_value_valid (valueValid),
        .i_hex_mode    (hexMode),
        .i_blank_lz    (blankLz),
        .i_blink_en    (blinkEn),
        .o_busy        (busy),
        .o_anode       (anode),
        .o_seg         (seg)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n rising edges and settle 1 unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a load for exactly one accepting edge
    task automatic applyStimulus(input logic [13:0] v, input logic hex);
        value      = v;
        hexMode    = hex;
        valueValid = 1'b1;
        tick(1);
        valueValid = 1'b0;
    endtask

    // Wait (bounded) until the converter is idle
    task automatic waitIdle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (busy === 1'b0) ok = 1'b1;
            else tick(1);
        end
    endtask

    // Wait (bounded) until digit d is the one being driven
    task automatic waitDigit(input int d, output bit found);
        logic [3:0] want;
        want  = ~(4'b0001 << d);
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (anode === want) found = 1'b1;
            else tick(1);
        end
    endtask

    // Reset from time zero and release 2 units after an edge, so the next edge is edge 1
    task automatic doReset();
        rstN = 1'b0;
        @(posedge clk);
        #2;
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b1;
        #1;
        rstN = 1'b0;
        #2;
        testsRun++;
        if (anode !== 4'b1111) begin
            testsFailed++;
            $display("[TB] FAIL reset_anode: got %b want %b", anode, 4'b1111);
        end
        testsRun++;
        if (seg !== SEG_BLANK) begin
            testsFailed++;
            $display("[TB] FAIL reset_seg: got %b want %b", seg, SEG_BLANK);
        end
        testsRun++;
        if (busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_busy: got %b want 0", busy);
        end
        @(posedge clk);
        #2;
        rstN = 1'b1;
        tick(1);
        testsRun++;
        if (anode !== 4'b1110 || seg !== SEG_0) begin
            testsFailed++;
            $display("[TB] FAIL scan_edge1: got anode %b seg %b want 1110 %b", anode, seg, SEG_0);
        end
        tick(8);
        testsRun++;
        if (anode !== 4'b1110) begin
            testsFailed++;
            $display("[TB] FAIL scan_edge9: got %b want 1110", anode);
        end
        tick(1);
        testsRun++;
        if (anode !== 4'b1101 || seg !== SEG_0) begin
            testsFailed++;
            $display("[TB] FAIL scan_edge10: got anode %b seg %b want 1101 %b", anode, seg, SEG_0);
        end
        tick(10);
        testsRun++;
        if (anode !== 4'b1011) begin
            testsFailed++;
            $display("[TB] FAIL scan_edge20: got %b want 1011", anode);
        end
        tick(10);
        testsRun++;
        if (anode !== 4'b0111) begin
            testsFailed++;
            $display("[TB] FAIL scan_edge30: got %b want 0111", anode);
        end
        tick(10);
        testsRun++;
        if (anode !== 4'b1110) begin
            testsFailed++;
            $display("[TB] FAIL scan_wrap_edge40: got %b want 1110", anode);
        end
    endtask

    task automatic test_decimal_load();
        logic [6:0] exp [4];
        int  busyCycles;
        int  staleBad;
        bit  found;
        exp = '{SEG_4, SEG_3, SEG_2, SEG_1};
        blankLz = 1'b0;
        applyStimulus(14'd1234, 1'b0);
        busyCycles = 0;
        staleBad   = 0;
        while (busy === 1'b1 && busyCycles < 100) begin
            busyCycles++;
            if (seg !== SEG_0) staleBad++;
            tick(1);
        end
        testsRun++;
        if (busyCycles != 14) begin
            testsFailed++;
            $display("[TB] FAIL dec_busy_len: got %0d cycles want 14", busyCycles);
        end
        testsRun++;
        if (staleBad != 0) begin
            testsFailed++;
            $display("[TB] FAIL dec_old_shown: got %0d changed samples want 0", staleBad);
        end
        for (int d = 0; d < 4; d++) begin
            waitDigit(d, found);
            testsRun++;
            if (!found || seg !== exp[d]) begin
                testsFailed++;
                $display("[TB] FAIL dec1234_digit%0d: got %b (found=%0d) want %b", d, seg, found, exp[d]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [13:0] vals [3];
        logic [6:0]  want [3];
        bit ok;
        bit found;
        vals = '{14'd9999, 14'd10000, 14'd12345};
        want = '{SEG_9, SEG_DASH, SEG_DASH};
        for (int v = 0; v < 3; v++) begin
            applyStimulus(vals[v], 1'b0);
            waitIdle(ok);
            testsRun++;
            if (!ok) begin
                testsFailed++;
                $display("[TB] FAIL ovf_idle_%0d: got busy stuck want idle", vals[v]);
            end
            for (int d = 0; d < 4; d++) begin
                waitDigit(d, found);
                testsRun++;
                if (!found || seg !== want[v]) begin
                    testsFailed++;
                    $display("[TB] FAIL ovf_%0d_digit%0d: got %b want %b", vals[v], d, seg, want[v]);
                end
            end
        end
    endtask

    task automatic test_hex();
        logic [6:0] exp [4];
        logic [6:0] firstSeg;
        logic [3:0] firstAnode;
        logic [6:0] firstWant;
        int busySeen;
        bit found;
        exp = '{SEG_F, SEG_7, SEG_A, SEG_3};
        applyStimulus(14'h3A7F, 1'b1);
        firstSeg   = seg;
        firstAnode = anode;
        firstWant  = SEG_BLANK;
        for (int d = 0; d < 4; d++) begin
            if (firstAnode == ~(4'b0001 << d)) firstWant = exp[d];
        end
        testsRun++;
        if (firstSeg !== firstWant) begin
            testsFailed++;
            $display("[TB] FAIL hex_next_edge: got %b want %b", firstSeg, firstWant);
        end
        busySeen = 0;
        for (int d = 0; d < 4; d++) begin
            if (busy !== 1'b0) busySeen++;
            waitDigit(d, found);
            testsRun++;
            if (!found || seg !== exp[d]) begin
                testsFailed++;
                $display("[TB] FAIL hex_digit%0d: got %b want %b", d, seg, exp[d]);
            end
        end
        testsRun++;
        if (busySeen != 0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL hex_busy: got %0d busy samples want 0", busySeen);
        end
    endtask

    task automatic test_blank_lz();
        logic [6:0] exp7 [4];
        logic [6:0] exp0 [4];
        logic [6:0] exp1005 [4];
        bit ok;
        bit found;
        exp7    = '{SEG_7, SEG_BLANK, SEG_BLANK, SEG_BLANK};
        exp0    = '{SEG_0, SEG_BLANK, SEG_BLANK, SEG_BLANK};
        exp1005 = '{SEG_5, SEG_0, SEG_0, SEG_1};
        blankLz = 1'b1;
        applyStimulus(14'd7, 1'b0);
        waitIdle(ok);
        for (int d = 0; d < 4; d++) begin
            waitDigit(d, found);
            testsRun++;
            if (!ok || !found || seg !== exp7[d]) begin
                testsFailed++;
                $display("[TB] FAIL blank7_digit%0d: got %b want %b", d, seg, exp7[d]);
            end
        end
        applyStimulus(14'd0, 1'b0);
        waitIdle(ok);
        for (int d = 0; d < 4; d++) begin
            waitDigit(d, found);
            testsRun++;
            if (!ok || !found || seg !== exp0[d]) begin
                testsFailed++;
                $display("[TB] FAIL blank0_digit%0d: got %b want %b", d, seg, exp0[d]);
            end
        end
        applyStimulus(14'd1005, 1'b0);
        waitIdle(ok);
        for (int d = 0; d < 4; d++) begin
            waitDigit(d, found);
            testsRun++;
            if (!ok || !found || seg !== exp1005[d]) begin
                testsFailed++;
                $display("[TB] FAIL blank1005_digit%0d: got %b want %b", d, seg, exp1005[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp56 [4];
        logic [6:0] exp1234 [4];
        bit ok;
        bit found;
        exp56   = '{SEG_6, SEG_5, SEG_BLANK, SEG_BLANK};
        exp1234 = '{SEG_4, SEG_3, SEG_2, SEG_1};
        blankLz = 1'b1;
        applyStimulus(14'd56, 1'b0);
        tick(3);
        applyStimulus(14'd99, 1'b0);
        waitIdle(ok);
        for (int d = 0; d < 4; d++) begin
            waitDigit(d, found);
            testsRun++;
            if (!ok || !found || seg !== exp56[d]) begin
                testsFailed++;
                $display("[TB] FAIL ignore_digit%0d: got %b want %b", d, seg, exp56[d]);
            end
        end
        blankLz    = 1'b0;
        value      = 14'd1234;
        hexMode    = 1'b0;
        valueValid = 1'b1;
        tick(1);
        testsRun++;
        if (busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL held_first_accept: got busy %b want 1", busy);
        end
        tick(13);
        testsRun++;
        if (busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL held_busy_last: got busy %b want 1", busy);
        end
        tick(1);
        testsRun++;
        if (busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL held_busy_fall: got busy %b want 0", busy);
        end
        tick(1);
        testsRun++;
        if (busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL held_reaccept: got busy %b want 1", busy);
        end
        valueValid = 1'b0;
        waitIdle(ok);
        for (int d = 0; d < 4; d++) begin
            waitDigit(d, found);
            testsRun++;
            if (!ok || !found || seg !== exp1234[d]) begin
                testsFailed++;
                $display("[TB] FAIL held_digit%0d: got %b want %b", d, seg, exp1234[d]);
            end
        end
    endtask

    task automatic test_reset_mid_conversion();
        bit found;
        blankLz = 1'b0;
        applyStimulus(14'd5678, 1'b0);
        tick(3);
        #3;
        rstN = 1'b0;
        #1;
        testsRun++;
        if (busy !== 1'b0 || anode !== 4'b1111 || seg !== SEG_BLANK) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: got busy %b anode %b seg %b want 0 1111 %b", busy, anode, seg, SEG_BLANK);
        end
        @(posedge clk);
        #2;
        rstN = 1'b1;
        tick(1);
        testsRun++;
        if (busy !== 1'b0 || anode !== 4'b1110 || seg !== SEG_0) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_d0: got busy %b anode %b seg %b want 0 1110 %b", busy, anode, seg, SEG_0);
        end
        for (int d = 1; d < 4; d++) begin
            waitDigit(d, found);
            testsRun++;
            if (!found || seg !== SEG_0 || busy !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL post_reset_digit%0d: got %b busy %b want %b busy 0", d, seg, busy, SEG_0);
            end
        end
    endtask

    task automatic test_blink();
        int offBad;
        blinkEn = 1'b1;
        doReset();
        tick(99);
        testsRun++;
        if (anode !== 4'b1101) begin
            testsFailed++;
            $display("[TB] FAIL blink_on_edge99: got %b want 1101", anode);
        end
        tick(1);
        offBad = 0;
        for (int k = 100; k < 200; k++) begin
            if (anode !== 4'b1111) offBad++;
            tick(1);
        end
        testsRun++;
        if (offBad != 0) begin
            testsFailed++;
            $display("[TB] FAIL blink_off_phase: got %0d lit samples want 0", offBad);
        end
        testsRun++;
        if (anode !== 4'b1110) begin
            testsFailed++;
            $display("[TB] FAIL blink_on_edge200: got %b want 1110", anode);
        end
        tick(120);
        testsRun++;
        if (anode !== 4'b1111) begin
            testsFailed++;
            $display("[TB] FAIL blink_off_edge320: got %b want 1111", anode);
        end
        blinkEn = 1'b0;
        tick(1);
        testsRun++;
        if (anode !== 4'b1110) begin
            testsFailed++;
            $display("[TB] FAIL blink_forced_on: got %b want 1110", anode);
        end
        tick(9);
        blinkEn = 1'b1;
        tick(1);
        testsRun++;
        if (anode !== 4'b1111) begin
            testsFailed++;
            $display("[TB] FAIL blink_phase_kept: got %b want 1111", anode);
        end
        tick(69);
        testsRun++;
        if (anode !== 4'b1110) begin
            testsFailed++;
            $display("[TB] FAIL blink_on_edge400: got %b want 1110", anode);
        end
        blinkEn = 1'b0;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        value       = '0;
        valueValid  = 1'b0;
        hexMode     = 1'b0;
        blankLz     = 1'b0;
        blinkEn     = 1'b0;
        rstN        = 1'b1;

        test_reset();
        test_decimal_load();
        test_overflow();
        test_hex();
        test_blank_lz();
        test_back_to_back();
        test_reset_mid_conversion();
        test_blink();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
